// File: rtl/control_sequencer_pkg.sv
// Shared constants for the microcode sequencer: control-word bit positions,
// word and address widths, and the positions of the stored ALU flags.
package control_sequencer_pkg;

    localparam int CTRL_W = 16;
    localparam int ADDR_W = 9;

    localparam int HLT = 15;
    localparam int MI  = 14;
    localparam int RI  = 13;
    localparam int RO  = 12;
    localparam int IO  = 11;
    localparam int II  = 10;
    localparam int AI  = 9;
    localparam int AO  = 8;
    localparam int EO  = 7;
    localparam int SU  = 6;
    localparam int BI  = 5;
    localparam int OI  = 4;
    localparam int CE  = 3;
    localparam int CO  = 2;
    localparam int J   = 1;
    localparam int FI  = 0;

    localparam int CF = 1;
    localparam int ZF = 0;

endpackage

// File: rtl/microstep_counter.sv
// Microstep counter: wraps after MAX_STEP-1, ends an instruction early on an
// all-zero control word past the fetch steps, and freezes on a HLT word.
module microstep_counter
    import control_sequencer_pkg::*;
#(
    parameter int STEP_W      = 3,
    parameter int MAX_STEP    = 5,
    parameter int FETCH_STEPS = 2,
    parameter int END_ON_ZERO = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    input  logic [CTRL_W-1:0] ctrl_word,
    output logic [STEP_W-1:0] step
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEP - 1);
    localparam logic [STEP_W:0]   FETCH_END = (STEP_W + 1)'(FETCH_STEPS);
    localparam bit                EARLY_EN  = (END_ON_ZERO != 0);

    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] step_d;

    // Decisions on ctrl_word are only taken when advancing, so an undriven
    // ROM output during a stall cannot reach the register.
    always_comb begin
        step_d = step_q;
        if (advance) begin
            if (ctrl_word[HLT]) begin
                step_d = step_q;
            end else if (step_q >= LAST_STEP) begin
                step_d = '0;
            end else if (EARLY_EN && (ctrl_word == '0) && ({1'b0, step_q} >= FETCH_END)) begin
                step_d = '0;
            end else begin
                step_d = step_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_q <= '0;
        end else begin
            step_q <= step_d;
        end
    end

    assign step = step_q;

endmodule

// File: rtl/control_sequencer.sv
// Microcode sequencer: forms the ROM address {CF, ZF, opcode, step}, keeps the
// ALU flags and halt latch, and exports the datapath run qualifier.
module control_sequencer #(
    parameter  int OPC_W       = 4,
    parameter  int STEP_W      = 3,
    parameter  int FLAG_W      = 2,
    parameter  int MAX_STEP    = 5,
    parameter  int FETCH_STEPS = 2,
    parameter  int END_ON_ZERO = 1,
    localparam int ADDR_W      = FLAG_W + OPC_W + STEP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step_en,
    input  logic [OPC_W-1:0]  opcode,
    input  logic              carry_in,
    input  logic              zero_in,
    input  logic [15:0]       ctrl_word,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [FLAG_W-1:0] flags,
    output logic [STEP_W-1:0] step,
    output logic              instr_start,
    output logic              halted,
    output logic              run
);

    import control_sequencer_pkg::*;

    logic [FLAG_W-1:0] flags_q;
    logic [FLAG_W-1:0] flags_d;
    logic              halted_q;
    logic              halted_d;
    logic [STEP_W-1:0] step_w;

    assign run = step_en & ~halted_q;

    microstep_counter #(
        .STEP_W      (STEP_W),
        .MAX_STEP    (MAX_STEP),
        .FETCH_STEPS (FETCH_STEPS),
        .END_ON_ZERO (END_ON_ZERO)
    ) u_step (
        .clk       (clk),
        .reset     (reset),
        .advance   (run),
        .ctrl_word (ctrl_word),
        .step      (step_w)
    );

    // FI and HLT act independently so a combined word both loads and halts.
    always_comb begin
        flags_d  = flags_q;
        halted_d = halted_q;
        if (run) begin
            if (ctrl_word[FI]) begin
                flags_d     = '0;
                flags_d[CF] = carry_in;
                flags_d[ZF] = zero_in;
            end
            if (ctrl_word[HLT]) begin
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            flags_q  <= flags_d;
            halted_q <= halted_d;
        end
    end

    assign rom_addr    = {flags_q, opcode, step_w};
    assign flags       = flags_q;
    assign step        = step_w;
    assign instr_start = (step_w == '0);
    assign halted      = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer with hand-computed expectations.
module tb_control_sequencer;

    logic       clk;
    logic       reset;
    logic       step_en;
    logic [3:0] opcode;
    logic       carry_in;
    logic       zero_in;
    logic [15:0] ctrl_word;
    logic [8:0] rom_addr;
    logic [1:0] flags;
    logic [2:0] step;
    logic       instr_start;
    logic       halted;
    logic       run;

    int nchk = 0;
    int nerr = 0;

    control_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .step_en     (step_en),
        .opcode      (opcode),
        .carry_in    (carry_in),
        .zero_in     (zero_in),
        .ctrl_word   (ctrl_word),
        .rom_addr    (rom_addr),
        .flags       (flags),
        .step        (step),
        .instr_start (instr_start),
        .halted      (halted),
        .run         (run)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; step_en = 1'b0; opcode = 4'h1;
        carry_in = 1'b0; zero_in = 1'b0; ctrl_word = 16'h0004;
        tick();
        nchk++; if (step !== 3'd0) begin nerr++; $display("FAIL reset_step got %0d want 0", step); end
        nchk++; if (flags !== 2'b00) begin nerr++; $display("FAIL reset_flags got %b want 00", flags); end
        nchk++; if (halted !== 1'b0) begin nerr++; $display("FAIL reset_halted got %b want 0", halted); end
        nchk++; if (instr_start !== 1'b1) begin nerr++; $display("FAIL reset_istart got %b want 1", instr_start); end
        nchk++; if (rom_addr !== 9'h008) begin nerr++; $display("FAIL reset_addr got %h want 008", rom_addr); end
        nchk++; if (run !== 1'b0) begin nerr++; $display("FAIL reset_run got %b want 0", run); end
        reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_free_run();
        logic [2:0] exp_steps [6];
        exp_steps = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        pulse_reset();
        opcode = 4'h1; ctrl_word = 16'h0004; step_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            nchk++; if (step !== exp_steps[i]) begin nerr++; $display("FAIL run_step[%0d] got %0d want %0d", i, step, exp_steps[i]); end
            nchk++; if (instr_start !== (exp_steps[i] == 3'd0)) begin nerr++; $display("FAIL run_istart[%0d] got %b", i, instr_start); end
            nchk++; if (rom_addr !== (9'h008 + 9'(exp_steps[i]))) begin nerr++; $display("FAIL run_addr[%0d] got %h want %h", i, rom_addr, 9'h008 + 9'(exp_steps[i])); end
            tick();
        end
        $display("test_free_run done");
    endtask

    task automatic test_early_end();
        pulse_reset();
        opcode = 4'h1; ctrl_word = 16'h0000; step_en = 1'b1;
        tick();
        nchk++; if (step !== 3'd1) begin nerr++; $display("FAIL zero_fetch0 got %0d want 1", step); end
        tick();
        nchk++; if (step !== 3'd2) begin nerr++; $display("FAIL zero_fetch1 got %0d want 2", step); end
        tick();
        nchk++; if (step !== 3'd0) begin nerr++; $display("FAIL zero_early_end got %0d want 0", step); end
        $display("test_early_end done");
    endtask

    task automatic test_flags();
        pulse_reset();
        opcode = 4'h7; ctrl_word = 16'h0004; step_en = 1'b1;
        carry_in = 1'b0; zero_in = 1'b0;
        tick(); tick();
        ctrl_word = 16'h0001; carry_in = 1'b1; zero_in = 1'b0;
        tick();
        nchk++; if (flags !== 2'b10) begin nerr++; $display("FAIL fi_flags got %b want 10", flags); end
        nchk++; if (rom_addr !== 9'h13B) begin nerr++; $display("FAIL fi_addr got %h want 13b", rom_addr); end
        ctrl_word = 16'h0004; carry_in = 1'b0; zero_in = 1'b1;
        tick();
        nchk++; if (flags !== 2'b10) begin nerr++; $display("FAIL nofi_flags_a got %b want 10", flags); end
        carry_in = 1'b1; zero_in = 1'b1;
        tick();
        nchk++; if (flags !== 2'b10) begin nerr++; $display("FAIL nofi_flags_b got %b want 10", flags); end
        nchk++; if (rom_addr !== 9'h138) begin nerr++; $display("FAIL nofi_addr got %h want 138", rom_addr); end
        $display("test_flags done");
    endtask

    task automatic test_halt();
        pulse_reset();
        opcode = 4'h7; ctrl_word = 16'h0004; step_en = 1'b1;
        carry_in = 1'b1; zero_in = 1'b1;
        tick(); tick();
        ctrl_word = 16'h8001;
        #1;
        nchk++; if (rom_addr !== 9'h03A) begin nerr++; $display("FAIL halt_pre_addr got %h want 03a", rom_addr); end
        tick();
        nchk++; if (halted !== 1'b1) begin nerr++; $display("FAIL halt_latch got %b want 1", halted); end
        nchk++; if (run !== 1'b0) begin nerr++; $display("FAIL halt_run got %b want 0", run); end
        nchk++; if (step !== 3'd2) begin nerr++; $display("FAIL halt_step got %0d want 2", step); end
        nchk++; if (flags !== 2'b11) begin nerr++; $display("FAIL halt_flags got %b want 11", flags); end
        carry_in = 1'b0; zero_in = 1'b0; ctrl_word = 16'h0001;
        tick(); tick();
        ctrl_word = 16'hxxxx;
        tick();
        nchk++; if (step !== 3'd2) begin nerr++; $display("FAIL halted_step got %0d want 2", step); end
        nchk++; if (flags !== 2'b11) begin nerr++; $display("FAIL halted_flags got %b want 11", flags); end
        nchk++; if (rom_addr !== 9'h1BA) begin nerr++; $display("FAIL halted_addr got %h want 1ba", rom_addr); end
        ctrl_word = 16'h0004;
        pulse_reset();
        nchk++; if (halted !== 1'b0) begin nerr++; $display("FAIL unhalt got %b want 0", halted); end
        nchk++; if (step !== 3'd0) begin nerr++; $display("FAIL unhalt_step got %0d want 0", step); end
        nchk++; if (run !== 1'b1) begin nerr++; $display("FAIL unhalt_run got %b want 1", run); end
        $display("test_halt done");
    endtask

    task automatic test_single_step();
        pulse_reset();
        opcode = 4'h2; ctrl_word = 16'h0004; step_en = 1'b1;
        tick(); tick(); tick();
        step_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) ctrl_word = 16'hxxxx;
            tick();
            nchk++; if (step !== 3'd3) begin nerr++; $display("FAIL stall_step[%0d] got %0d want 3", i, step); end
        end
        nchk++; if (flags !== 2'b00) begin nerr++; $display("FAIL stall_flags got %b want 00", flags); end
        ctrl_word = 16'h0004; step_en = 1'b1;
        tick();
        step_en = 1'b0;
        nchk++; if (step !== 3'd4) begin nerr++; $display("FAIL pulse_step got %0d want 4", step); end
        tick();
        nchk++; if (step !== 3'd4) begin nerr++; $display("FAIL pulse_hold got %0d want 4", step); end
        $display("test_single_step done");
    endtask

    task automatic test_async_reset();
        pulse_reset();
        opcode = 4'h3; ctrl_word = 16'h0005; step_en = 1'b1;
        carry_in = 1'b1; zero_in = 1'b1;
        tick();
        ctrl_word = 16'h0004;
        tick(); tick(); tick();
        nchk++; if (step !== 3'd4) begin nerr++; $display("FAIL pre_areset_step got %0d want 4", step); end
        nchk++; if (flags !== 2'b11) begin nerr++; $display("FAIL pre_areset_flags got %b want 11", flags); end
        #2;
        reset = 1'b1;
        #1;
        nchk++; if (step !== 3'd0) begin nerr++; $display("FAIL areset_step got %0d want 0", step); end
        nchk++; if (flags !== 2'b00) begin nerr++; $display("FAIL areset_flags got %b want 00", flags); end
        nchk++; if (rom_addr !== 9'h018) begin nerr++; $display("FAIL areset_addr got %h want 018", rom_addr); end
        nchk++; if (instr_start !== 1'b1) begin nerr++; $display("FAIL areset_istart got %b want 1", instr_start); end
        reset = 1'b0;
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_early_end();
        test_flags();
        test_halt();
        test_single_step();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule
